noc_input_unit_p: RTL

- Parametrised next-generation input unit for one router input port. It decodes the header destination, computes an XY or YX route, and buffers the flit in one of NUM_DIRS per-direction virtual-channel FIFOs.
- Each FIFO feeds its own output-side valid/ready port.
- Adds occupancy reporting, a saturating stall counter and a selectable routing mode. The input handshake is free of combinational valid-to-ready dependency.

---
 rtl/noc_input_unit_p_pkg.sv | 41 ++++
 rtl/noc_vc_fifo.sv | 68 ++++++
 rtl/noc_input_unit_p.sv | 85 ++++++++
 3 files changed

// File: rtl/noc_input_unit_p_pkg.sv
// Shared NoC definitions: direction codes, routing modes and the route-compute
// function that any router in the mesh can reuse.
package noc_input_unit_p_pkg;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_S = 3'd1,
    DIR_E = 3'd2,
    DIR_W = 3'd3,
    DIR_L = 3'd4
  } dir_e;

  localparam logic RT_XY = 1'b0;
  localparam logic RT_YX = 1'b1;

  // Coordinates are zero-extended to this width before comparison.
  localparam int MAX_COORD_W = 8;

  function automatic dir_e compute_route(
    input logic [MAX_COORD_W-1:0] cur_x,
    input logic [MAX_COORD_W-1:0] cur_y,
    input logic [MAX_COORD_W-1:0] dst_x,
    input logic [MAX_COORD_W-1:0] dst_y,
    input logic                   alg
  );
    dir_e x_dir;
    dir_e y_dir;
    logic x_eq;
    logic y_eq;
    x_eq  = (dst_x == cur_x);
    y_eq  = (dst_y == cur_y);
    x_dir = (dst_x > cur_x) ? DIR_E : DIR_W;
    y_dir = (dst_y > cur_y) ? DIR_N : DIR_S;
    if (alg == RT_XY) begin
      compute_route = !x_eq ? x_dir : (!y_eq ? y_dir : DIR_L);
    end else begin
      compute_route = !y_eq ? y_dir : (!x_eq ? x_dir : DIR_L);
    end
  endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Show-ahead virtual-channel FIFO: head entry is always visible on rd_data,
// write and read may both fire in one cycle.
module noc_vc_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_fire;
  logic                  rd_fire;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full FIFO refuses writes even when it is popped in the same cycle.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/noc_input_unit_p.sv
// Router input port: decodes the header destination, routes XY or YX, and
// steers the flit into one of NUM_DIRS show-ahead VC FIFOs.
module noc_input_unit_p
  import noc_input_unit_p_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int ROUTER_ADDR_WIDTH = 4,
  parameter int NUM_DIRS          = 5,
  parameter int VC_DEPTH          = 4,
  parameter int ROUTING_ALGORITHM = 0,
  parameter int STALL_CNT_WIDTH   = 16,
  localparam int CNT_W            = $clog2(VC_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ROUTER_ADDR_WIDTH-1:0]   router_addr,
  input  logic [DATA_WIDTH-1:0]          in_packet,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NUM_DIRS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_DIRS-1:0]            out_valid,
  input  logic [NUM_DIRS-1:0]            out_ready,
  output logic [NUM_DIRS*CNT_W-1:0]      vc_count,
  output logic [2:0]                     route_dir,
  output logic [STALL_CNT_WIDTH-1:0]     stall_count,
  input  logic                           stall_clr
);

  localparam int HW = ROUTER_ADDR_WIDTH / 2;

  logic [ROUTER_ADDR_WIDTH-1:0] dst_addr;
  logic [NUM_DIRS-1:0]          vc_full;
  logic [NUM_DIRS-1:0]          vc_empty;
  logic [NUM_DIRS-1:0]          wr_en;
  logic [STALL_CNT_WIDTH-1:0]   stall_q, stall_d;

  assign dst_addr  = in_packet[DATA_WIDTH-1 -: ROUTER_ADDR_WIDTH];
  assign route_dir = compute_route(
    MAX_COORD_W'(router_addr[ROUTER_ADDR_WIDTH-1 -: HW]),
    MAX_COORD_W'(router_addr[HW-1:0]),
    MAX_COORD_W'(dst_addr[ROUTER_ADDR_WIDTH-1 -: HW]),
    MAX_COORD_W'(dst_addr[HW-1:0]),
    1'(ROUTING_ALGORITHM)
  );

  // Ready depends only on the routed VC, never on in_valid.
  assign in_ready = !vc_full[route_dir];

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_vc
    assign wr_en[d]     = in_valid && in_ready && (route_dir == 3'(d));
    assign out_valid[d] = !vc_empty[d];

    noc_vc_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (VC_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en[d]),
      .wr_data(in_packet),
      .full   (vc_full[d]),
      .rd_en  (out_ready[d]),
      .rd_data(out_data[d*DATA_WIDTH +: DATA_WIDTH]),
      .empty  (vc_empty[d]),
      .count  (vc_count[d*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (in_valid && !in_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_count = stall_q;

endmodule
